// File: rtl/dummy_accelerator_arbiter.sv
// Round-robin issue arbiter in front of a shared accelerator. The winner's
// ID is queued in order so results are routed back to their owners.
module dummy_accelerator_arbiter #(
  parameter int N_REQ = 2,
  parameter int CTL_W = 8,
  parameter int DEPTH = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*CTL_W-1:0] req_ctl_i,
  output logic                   acc_valid_o,
  input  logic                   acc_ready_i,
  output logic [CTL_W-1:0]       acc_ctl_o,
  input  logic                   acc_rvalid_i,
  output logic                   acc_rready_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic [CNT_W-1:0]       inflight_o,
  output logic                   spurious_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  rr_ptr, win, cand, head;
  logic [ID_W-1:0]  id_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             found, full, empty, issue, pop;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = id_mem[rd_ptr];

  // Scan from the RR pointer upward with wrap; first valid requester wins.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Outputs are gated by rst_i so they drop immediately on an async reset.
  always_comb begin
    acc_valid_o = !rst_i && found && !full;
    acc_ctl_o   = '0;
    req_ready_o = '0;
    if (acc_valid_o) begin
      acc_ctl_o        = req_ctl_i[int'(win)*CTL_W +: CTL_W];
      req_ready_o[win] = acc_ready_i;
    end
    issue = acc_valid_o && acc_ready_i;
  end

  always_comb begin
    rsp_valid_o  = '0;
    acc_rready_o = !rst_i && !empty && rsp_ready_i[head];
    if (!rst_i && !empty && acc_rvalid_i) rsp_valid_o[head] = 1'b1;
    pop = acc_rvalid_i && acc_rready_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      spurious_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) id_mem[i] <= '0;
    end else begin
      spurious_o <= acc_rvalid_i && empty;
      if (flush_i) begin
        rr_ptr <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (issue) begin
          id_mem[wr_ptr] <= win;
          wr_ptr         <= wr_ptr + 1'b1;
          rr_ptr         <= (int'(win) == N_REQ-1) ? '0 : win + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({issue, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign inflight_o = cnt;
endmodule

// File: tb/tb_dummy_accelerator_arbiter.sv
// Scenario bench: expected owner IDs are queued at issue and popped when the
// result is routed back.
module tb_dummy_accelerator_arbiter;
  localparam int N_REQ = 2, CTL_W = 8, DEPTH = 4, CNT_W = 3;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [N_REQ-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N_REQ*CTL_W-1:0] req_ctl = '0;
  logic acc_valid, acc_ready = 1'b0, acc_rvalid = 1'b0, acc_rready, spurious;
  logic [CTL_W-1:0] acc_ctl;
  logic [CNT_W-1:0] inflight;

  int checks = 0, errors = 0;
  int q[$];
  int h;

  always #5 clk = ~clk;

  dummy_accelerator_arbiter #(.N_REQ(N_REQ), .CTL_W(CTL_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ctl_i(req_ctl),
    .acc_valid_o(acc_valid), .acc_ready_i(acc_ready), .acc_ctl_o(acc_ctl),
    .acc_rvalid_i(acc_rvalid), .acc_rready_o(acc_rready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .inflight_o(inflight), .spurious_o(spurious)
  );

  task automatic idle();
    req_valid = '0; acc_ready = 0; acc_rvalid = 0; rsp_ready = '0; flush = 0;
  endtask

  task automatic do_flush();
    @(negedge clk); idle(); flush = 1;
    @(negedge clk); flush = 0;
    q.delete();
  endtask

  // Assumes RR pointer at 0: grants alternate 0,1,0,...
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); req_valid = 2'b11; acc_ready = 1; acc_rvalid = 0; #1;
      checks++; if (req_ready !== (2'(1) << (i % 2))) begin errors++; $display("FAIL fill_grant[%0d] got %b exp %b", i, req_ready, 2'(1) << (i % 2)); end
      q.push_back(i % 2);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); req_valid = '0; acc_ready = 0; acc_rvalid = 1; rsp_ready = 2'b11; #1;
      h = (q.size() > 0) ? q.pop_front() : 0;
      checks++; if (rsp_valid !== (2'(1) << h)) begin errors++; $display("FAIL drain_rsp[%0d] got %b exp %b", i, rsp_valid, 2'(1) << h); end
      checks++; if (acc_rready !== 1'b1) begin errors++; $display("FAIL drain_rready[%0d] got %b exp 1", i, acc_rready); end
    end
    @(negedge clk); idle(); #1;
    checks++; if (inflight !== '0) begin errors++; $display("FAIL drain_empty got %0d exp 0", inflight); end
  endtask

  task automatic test_reset();
    req_valid = 2'b11; acc_ready = 1; acc_rvalid = 1; rsp_ready = 2'b11; req_ctl = {8'hB1, 8'hA0}; #1;
    checks++; if (acc_valid !== 0 || req_ready !== '0 || acc_ctl !== '0) begin errors++; $display("FAIL reset_issue got v=%b r=%b c=%h exp 0", acc_valid, req_ready, acc_ctl); end
    checks++; if (rsp_valid !== '0 || acc_rready !== 0) begin errors++; $display("FAIL reset_rsp got v=%b r=%b exp 0", rsp_valid, acc_rready); end
    checks++; if (inflight !== '0 || spurious !== 0) begin errors++; $display("FAIL reset_state got cnt=%0d sp=%b exp 0", inflight, spurious); end
    @(negedge clk); idle(); rst = 0;
  endtask

  task automatic test_single();
    @(negedge clk); req_valid = 2'b01; req_ctl = {8'h00, 8'h05}; acc_ready = 1; #1;
    checks++; if (acc_ctl !== 8'h05) begin errors++; $display("FAIL single_ctl got %h exp 05", acc_ctl); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", req_ready); end
    q.push_back(0);
    @(negedge clk); idle(); #1;
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", inflight); end
    req_ctl = {8'hB1, 8'hA0};
    drain(1);
  endtask

  task automatic test_round_robin();
    do_flush();
    fill(4);
    @(negedge clk); #1;
    checks++; if (acc_valid !== 0 || req_ready !== '0) begin errors++; $display("FAIL rr_full got v=%b r=%b exp 0", acc_valid, req_ready); end
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL rr_cnt got %0d exp 4", inflight); end
    drain(4);
  endtask

  task automatic test_stall();
    do_flush();
    @(negedge clk); req_valid = 2'b01; acc_ready = 1; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_pre got %b exp 01", req_ready); end
    q.push_back(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req_valid = 2'b11; acc_ready = 0; #1;
      checks++; if (req_ready !== '0 || acc_valid !== 1 || acc_ctl !== 8'hB1) begin errors++; $display("FAIL stall_hold[%0d] got r=%b v=%b c=%h exp r=00 v=1 c=b1", i, req_ready, acc_valid, acc_ctl); end
    end
    acc_ready = 1; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_release got %b exp 10", req_ready); end
    q.push_back(1);
    @(negedge clk); acc_ready = 0; #1;
    checks++; if (acc_ctl !== 8'hA0 || inflight !== 3'd2) begin errors++; $display("FAIL stall_ptr got c=%h cnt=%0d exp c=a0 cnt=2", acc_ctl, inflight); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); idle(); acc_rvalid = 1; h = q[0]; rsp_ready = ~(2'(1) << h); #1;
    checks++; if (rsp_valid !== (2'(1) << h) || acc_rready !== 0) begin errors++; $display("FAIL bp_block got v=%b r=%b exp v=%b r=0", rsp_valid, acc_rready, 2'(1) << h); end
    @(negedge clk); #1;
    checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL bp_nopop got %0d exp 2", inflight); end
    rsp_ready = 2'(1) << h; #1;
    checks++; if (acc_rready !== 1) begin errors++; $display("FAIL bp_accept got %b exp 1", acc_rready); end
    void'(q.pop_front());
    @(negedge clk); rsp_ready = '0; #1;
    checks++; if (inflight !== 3'd1 || rsp_valid !== (2'(1) << q[0])) begin errors++; $display("FAIL bp_head got cnt=%0d v=%b exp cnt=1 v=%b", inflight, rsp_valid, 2'(1) << q[0]); end
    drain(1);
  endtask

  task automatic test_full_pop();
    do_flush();
    fill(4);
    @(negedge clk); req_valid = 2'b11; acc_ready = 1; acc_rvalid = 1; rsp_ready = 2'b11; #1;
    h = q.pop_front();
    checks++; if (acc_valid !== 0 || req_ready !== '0) begin errors++; $display("FAIL fullpop_block got v=%b r=%b exp 0", acc_valid, req_ready); end
    checks++; if (acc_rready !== 1 || rsp_valid !== (2'(1) << h)) begin errors++; $display("FAIL fullpop_rsp got r=%b v=%b exp r=1 v=%b", acc_rready, rsp_valid, 2'(1) << h); end
    @(negedge clk); acc_rvalid = 0; #1;
    checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL fullpop_cnt got %0d exp 3", inflight); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fullpop_reissue got %b exp 01", req_ready); end
    q.push_back(0);
    @(negedge clk); idle(); #1;
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL fullpop_refill got %0d exp 4", inflight); end
    drain(4);
  endtask

  task automatic test_flush_spurious();
    do_flush();
    fill(3);
    @(negedge clk); flush = 1; req_valid = 2'b11; acc_ready = 1; acc_rvalid = 1; rsp_ready = 2'b11;
    @(negedge clk); idle(); req_valid = 2'b11; #1;
    q.delete();
    checks++; if (inflight !== '0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", inflight); end
    checks++; if (acc_ctl !== 8'hA0) begin errors++; $display("FAIL flush_ptr got %h exp a0", acc_ctl); end
    req_valid = '0; acc_rvalid = 1; rsp_ready = 2'b11; #1;
    checks++; if (acc_rready !== 0 || rsp_valid !== '0 || spurious !== 0) begin errors++; $display("FAIL spur_comb got r=%b v=%b sp=%b exp 0", acc_rready, rsp_valid, spurious); end
    @(negedge clk); acc_rvalid = 0; #1;
    checks++; if (spurious !== 1) begin errors++; $display("FAIL spur_pulse got %b exp 1", spurious); end
    @(negedge clk); #1;
    checks++; if (spurious !== 0) begin errors++; $display("FAIL spur_clear got %b exp 0", spurious); end
  endtask

  task automatic test_reset_mid();
    do_flush();
    fill(2);
    @(negedge clk); req_valid = 2'b11; acc_ready = 1; acc_rvalid = 1; rsp_ready = 2'b11; #1;
    checks++; if (acc_valid !== 1 || acc_rready !== 1) begin errors++; $display("FAIL rstmid_pre got v=%b r=%b exp 1", acc_valid, acc_rready); end
    #1 rst = 1; #1;
    checks++; if (acc_valid !== 0 || req_ready !== '0 || acc_ctl !== '0) begin errors++; $display("FAIL rstmid_issue got v=%b r=%b c=%h exp 0", acc_valid, req_ready, acc_ctl); end
    checks++; if (rsp_valid !== '0 || acc_rready !== 0 || inflight !== '0) begin errors++; $display("FAIL rstmid_rsp got v=%b r=%b cnt=%0d exp 0", rsp_valid, acc_rready, inflight); end
    @(negedge clk); idle(); rst = 0; q.delete(); #1;
    checks++; if (inflight !== '0 || spurious !== 0) begin errors++; $display("FAIL rstmid_after got cnt=%0d sp=%b exp 0", inflight, spurious); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_full_pop();
    test_flush_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
